// File: rtl/d_line_var.sv
// d_line_var: multi-lane, runtime-programmable delay line. LANES x WIDTH data plus
// a valid tag ride through a circular buffer; the read tap trails the write pointer by dly_r.
module d_line_var #(
    parameter int WIDTH   = 12,
    parameter int LANES   = 2,
    parameter int MAX_LEN = 32,
    parameter int DEF_LEN = 32,
    localparam int DW     = $clog2(MAX_LEN + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   flush,
    input  logic                   cfg_ld,
    input  logic [DW-1:0]          dly_i,
    input  logic                   vld_i,
    input  logic [LANES*WIDTH-1:0] d_i,
    output logic [LANES*WIDTH-1:0] d_o,
    output logic                   vld_o,
    output logic [DW-1:0]          dly_o
);

    localparam int              PW     = $clog2(MAX_LEN);
    localparam int              EW     = LANES * WIDTH;
    localparam logic [DW:0]     LEN_X  = (DW+1)'(MAX_LEN);
    localparam logic [DW-1:0]   DEF_D  = DW'(DEF_LEN);
    localparam logic [PW-1:0]   LAST_P = PW'(MAX_LEN - 1);

    logic [EW-1:0]      mem_d [MAX_LEN];
    logic [MAX_LEN-1:0] mem_v;
    logic [PW-1:0]      wptr;
    logic [PW-1:0]      wptr_nxt;
    logic [DW-1:0]      dly_r;
    logic [DW-1:0]      dly_sat;
    logic [DW:0]        rd_sum;
    logic [DW:0]        rd_idx;

    always_comb begin
        dly_sat = dly_i;
        if (dly_i == '0) begin
            dly_sat = DW'(1);
        end else if ({1'b0, dly_i} > LEN_X) begin
            dly_sat = LEN_X[DW-1:0];
        end
    end

    assign wptr_nxt = (wptr == LAST_P) ? '0 : wptr + PW'(1);

    // Offset by MAX_LEN before subtracting so the tap index never goes negative,
    // which keeps non-power-of-2 depths correct.
    assign rd_sum = {{(DW+1-PW){1'b0}}, wptr} + LEN_X - {1'b0, dly_r};
    assign rd_idx = (rd_sum >= LEN_X) ? rd_sum - LEN_X : rd_sum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                mem_d[i] <= '0;
            end
            mem_v <= '0;
            wptr  <= '0;
            dly_r <= DEF_D;
        end else if (cfg_ld) begin
            dly_r <= dly_sat;
            mem_v <= '0;
        end else if (flush) begin
            mem_v <= '0;
        end else if (en) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                if (wptr == PW'(i)) begin
                    mem_d[i] <= d_i;
                    mem_v[i] <= vld_i;
                end
            end
            wptr <= wptr_nxt;
        end
    end

    always_comb begin
        d_o   = '0;
        vld_o = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (rd_idx == (DW+1)'(i)) begin
                d_o   = mem_d[i];
                vld_o = mem_v[i];
            end
        end
    end

    assign dly_o = dly_r;

endmodule

// File: tb/tb_d_line_var.sv
// Self-checking bench for d_line_var: two instances (default, and 4 lanes x depth 24)
// compared against a shift-register reference model.
module tb_d_line_var;

    localparam int WA  = 12;
    localparam int LA  = 2;
    localparam int MA  = 32;
    localparam int DWA = $clog2(MA + 1);
    localparam int WB  = 12;
    localparam int LB  = 4;
    localparam int MB  = 24;
    localparam int DWB = $clog2(MB + 1);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic                en_a, flush_a, cfg_a, vld_a, vld_oa;
    logic [DWA-1:0]      dly_ia, dly_oa;
    logic [LA*WA-1:0]    d_ia, d_oa;
    logic                en_b, flush_b, cfg_b, vld_b, vld_ob;
    logic [DWB-1:0]      dly_ib, dly_ob;
    logic [LB*WB-1:0]    d_ib, d_ob;

    d_line_var #(.WIDTH(WA), .LANES(LA), .MAX_LEN(MA), .DEF_LEN(MA)) dut_a (
        .clk(clk), .rst(rst_n), .en(en_a), .flush(flush_a), .cfg_ld(cfg_a),
        .dly_i(dly_ia), .vld_i(vld_a), .d_i(d_ia),
        .d_o(d_oa), .vld_o(vld_oa), .dly_o(dly_oa)
    );

    d_line_var #(.WIDTH(WB), .LANES(LB), .MAX_LEN(MB), .DEF_LEN(MB)) dut_b (
        .clk(clk), .rst(rst_n), .en(en_b), .flush(flush_b), .cfg_ld(cfg_b),
        .dly_i(dly_ib), .vld_i(vld_b), .d_i(d_ib),
        .d_o(d_ob), .vld_o(vld_ob), .dly_o(dly_ob)
    );

    int vectors = 0;
    int errors  = 0;

    // Reference: the last MAX_LEN enabled samples, oldest first; output is the sample dly entries back.
    logic [LA*WA:0] qa [MA];
    logic [LB*WB:0] qb [MB];
    int dly_ma, dly_mb;

    function automatic logic [LA*WA:0] exp_a();
        return qa[MA - dly_ma];
    endfunction

    function automatic logic [LB*WB:0] exp_b();
        return qb[MB - dly_mb];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < MA; i++) qa[i] = '0;
        for (int i = 0; i < MB; i++) qb[i] = '0;
        dly_ma = MA;
        dly_mb = MB;
    endtask

    task automatic step_a(input logic e, input logic f, input logic c,
                          input logic [DWA-1:0] dl, input logic v, input logic [LA*WA-1:0] d);
        en_a = e; flush_a = f; cfg_a = c; dly_ia = dl; vld_a = v; d_ia = d;
        @(posedge clk);
        if (c) begin
            dly_ma = (dl == 0) ? 1 : ((int'(dl) > MA) ? MA : int'(dl));
            for (int i = 0; i < MA; i++) qa[i][LA*WA] = 1'b0;
        end else if (f) begin
            for (int i = 0; i < MA; i++) qa[i][LA*WA] = 1'b0;
        end else if (e) begin
            for (int i = 0; i < MA - 1; i++) qa[i] = qa[i+1];
            qa[MA-1] = {v, d};
        end
        #1;
        en_a = 1'b0; flush_a = 1'b0; cfg_a = 1'b0;
    endtask

    task automatic step_b(input logic e, input logic f, input logic c,
                          input logic [DWB-1:0] dl, input logic v, input logic [LB*WB-1:0] d);
        en_b = e; flush_b = f; cfg_b = c; dly_ib = dl; vld_b = v; d_ib = d;
        @(posedge clk);
        if (c) begin
            dly_mb = (dl == 0) ? 1 : ((int'(dl) > MB) ? MB : int'(dl));
            for (int i = 0; i < MB; i++) qb[i][LB*WB] = 1'b0;
        end else if (f) begin
            for (int i = 0; i < MB; i++) qb[i][LB*WB] = 1'b0;
        end else if (e) begin
            for (int i = 0; i < MB - 1; i++) qb[i] = qb[i+1];
            qb[MB-1] = {v, d};
        end
        #1;
        en_b = 1'b0; flush_b = 1'b0; cfg_b = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            en_a = 1'($urandom); vld_a = 1'($urandom); d_ia = (LA*WA)'($urandom);
            en_b = 1'($urandom); vld_b = 1'($urandom); d_ib = (LB*WB)'({$urandom, $urandom});
            @(posedge clk); #1;
            vectors++;
            if ({vld_oa, d_oa, dly_oa} !== {1'b0, (LA*WA)'(0), DWA'(32)}) begin
                errors++;
                $display("FAIL reset_a: got vld=%b d=%h dly=%0d, want vld=0 d=0 dly=32", vld_oa, d_oa, dly_oa);
            end
            vectors++;
            if ({vld_ob, d_ob, dly_ob} !== {1'b0, (LB*WB)'(0), DWB'(24)}) begin
                errors++;
                $display("FAIL reset_b: got vld=%b d=%h dly=%0d, want vld=0 d=0 dly=24", vld_ob, d_ob, dly_ob);
            end
        end
        en_a = 1'b0; flush_a = 1'b0; cfg_a = 1'b0; en_b = 1'b0; flush_b = 1'b0; cfg_b = 1'b0;
        model_reset();
        rst_n = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            step_a(1'b1, 1'b0, 1'b0, '0, 1'b1, {WA'($urandom), WA'(k)});
            vectors++;
            if ({vld_oa, d_oa} !== exp_a()) begin
                errors++;
                $display("FAIL reset_ramp edge %0d: got %h, want %h", k, {vld_oa, d_oa}, exp_a());
            end
        end
        vectors++;
        if (d_oa[WA-1:0] !== WA'(1) || vld_oa !== 1'b1) begin
            errors++;
            $display("FAIL reset_ramp_first: got lane0=%h vld=%b, want lane0=001 vld=1", d_oa[WA-1:0], vld_oa);
        end
    endtask

    task automatic test_delay_load();
        step_a(1'b0, 1'b0, 1'b1, DWA'(5), 1'b0, '0);
        vectors++;
        if (dly_oa !== DWA'(5) || vld_oa !== 1'b0) begin
            errors++;
            $display("FAIL dly5_load: got dly=%0d vld=%b, want dly=5 vld=0", dly_oa, vld_oa);
        end
        for (int j = 1; j <= 12; j++) begin
            step_a(1'b1, 1'b0, 1'b0, '0, 1'b1, {WA'($urandom), WA'(100 + j)});
            vectors++;
            if (j >= 5 ? (vld_oa !== 1'b1 || d_oa[WA-1:0] !== WA'(100 + j - 4)) : (vld_oa !== 1'b0)) begin
                errors++;
                $display("FAIL dly5_ramp edge %0d: got vld=%b lane0=%0d", j, vld_oa, d_oa[WA-1:0]);
            end
            vectors++;
            if ({vld_oa, d_oa} !== exp_a()) begin
                errors++;
                $display("FAIL dly5_model edge %0d: got %h, want %h", j, {vld_oa, d_oa}, exp_a());
            end
        end
        step_a(1'b0, 1'b0, 1'b1, DWA'(0), 1'b0, '0);
        vectors++;
        if (dly_oa !== DWA'(1)) begin
            errors++;
            $display("FAIL dly0_sat: got dly=%0d, want 1", dly_oa);
        end
        for (int j = 0; j < 4; j++) begin
            logic [LA*WA-1:0] d;
            d = (LA*WA)'($urandom);
            step_a(1'b1, 1'b0, 1'b0, '0, 1'b1, d);
            vectors++;
            if (d_oa !== d || vld_oa !== 1'b1) begin
                errors++;
                $display("FAIL dly1_stage: got d=%h vld=%b, want d=%h vld=1", d_oa, vld_oa, d);
            end
        end
        step_a(1'b0, 1'b0, 1'b1, DWA'(40), 1'b0, '0);
        vectors++;
        if (dly_oa !== DWA'(32)) begin
            errors++;
            $display("FAIL dly40_sat: got dly=%0d, want 32", dly_oa);
        end
    endtask

    task automatic test_stall();
        int cnt;
        cnt = 0;
        step_a(1'b0, 1'b0, 1'b1, DWA'(3), 1'b0, '0);
        for (int i = 0; i < 40; i++) begin
            logic e;
            e = (i % 2 == 0);
            if (e) cnt++;
            step_a(e, 1'b0, 1'b0, '0, 1'b1, {WA'($urandom), e ? WA'(cnt) : WA'($urandom)});
            vectors++;
            if ({vld_oa, d_oa} !== exp_a()) begin
                errors++;
                $display("FAIL stall_model step %0d: got %h, want %h", i, {vld_oa, d_oa}, exp_a());
            end
            if (cnt >= 3) begin
                vectors++;
                if (vld_oa !== 1'b1 || d_oa[WA-1:0] !== WA'(cnt - 2)) begin
                    errors++;
                    $display("FAIL stall_seq step %0d: got vld=%b lane0=%0d, want 1/%0d", i, vld_oa, d_oa[WA-1:0], cnt - 2);
                end
            end
        end
    endtask

    task automatic test_flush();
        step_a(1'b0, 1'b0, 1'b1, DWA'(8), 1'b0, '0);
        for (int k = 1; k <= 20; k++) step_a(1'b1, 1'b0, 1'b0, '0, 1'b1, {WA'($urandom), WA'(k)});
        vectors++;
        if (vld_oa !== 1'b1 || d_oa[WA-1:0] !== WA'(13)) begin
            errors++;
            $display("FAIL flush_pre: got vld=%b lane0=%0d, want 1/13", vld_oa, d_oa[WA-1:0]);
        end
        step_a(1'b1, 1'b1, 1'b0, '0, 1'b1, (LA*WA)'($urandom));
        vectors++;
        if (vld_oa !== 1'b0 || d_oa[WA-1:0] !== WA'(13)) begin
            errors++;
            $display("FAIL flush_nowrite: got vld=%b lane0=%0d, want 0/13", vld_oa, d_oa[WA-1:0]);
        end
        for (int j = 1; j <= 10; j++) begin
            step_a(1'b1, 1'b0, 1'b0, '0, 1'b1, {WA'($urandom), WA'(200 + j)});
            vectors++;
            if (j >= 8 ? (vld_oa !== 1'b1 || d_oa[WA-1:0] !== WA'(200 + j - 7)) : (vld_oa !== 1'b0)) begin
                errors++;
                $display("FAIL flush_resume edge %0d: got vld=%b lane0=%0d", j, vld_oa, d_oa[WA-1:0]);
            end
            vectors++;
            if ({vld_oa, d_oa} !== exp_a()) begin
                errors++;
                $display("FAIL flush_model edge %0d: got %h, want %h", j, {vld_oa, d_oa}, exp_a());
            end
        end
    endtask

    task automatic test_random_mix();
        for (int i = 0; i < 400; i++) begin
            step_a(($urandom % 4) != 0, ($urandom % 15) == 0, ($urandom % 20) == 0,
                   DWA'($urandom), 1'($urandom), (LA*WA)'($urandom));
            vectors++;
            if ({vld_oa, d_oa, dly_oa} !== {exp_a(), DWA'(dly_ma)}) begin
                errors++;
                $display("FAIL random step %0d: got %h dly=%0d, want %h dly=%0d", i, {vld_oa, d_oa}, dly_oa, exp_a(), dly_ma);
            end
        end
    endtask

    task automatic test_wrap();
        step_b(1'b0, 1'b0, 1'b1, DWB'(24), 1'b0, '0);
        for (int n = 1; n <= 100; n++) begin
            step_b(1'b1, 1'b0, 1'b0, '0, 1'b1, {36'($urandom), WB'(n)});
            vectors++;
            if ({vld_ob, d_ob} !== exp_b()) begin
                errors++;
                $display("FAIL wrap_model edge %0d: got %h, want %h", n, {vld_ob, d_ob}, exp_b());
            end
            if (n >= 24) begin
                vectors++;
                if (vld_ob !== 1'b1 || d_ob[WB-1:0] !== WB'(n - 23)) begin
                    errors++;
                    $display("FAIL wrap_seq edge %0d: got vld=%b lane0=%0d, want 1/%0d", n, vld_ob, d_ob[WB-1:0], n - 23);
                end
            end
        end
    endtask

    task automatic test_lanes();
        step_b(1'b0, 1'b0, 1'b1, DWB'(7), 1'b0, '0);
        for (int i = 1; i <= 60; i++) begin
            logic [LB*WB-1:0] d;
            for (int k = 0; k < LB; k++) d[k*WB +: WB] = WB'(k * 'h400 + i);
            step_b(1'b1, 1'b0, 1'b0, '0, 1'b1, d);
            vectors++;
            if ({vld_ob, d_ob} !== exp_b()) begin
                errors++;
                $display("FAIL lanes_model edge %0d: got %h, want %h", i, {vld_ob, d_ob}, exp_b());
            end
            if (i >= 7) begin
                for (int k = 0; k < LB; k++) begin
                    vectors++;
                    if (d_ob[k*WB +: WB] !== WB'(k * 'h400 + i - 6)) begin
                        errors++;
                        $display("FAIL lane%0d edge %0d: got %h, want %h", k, i, d_ob[k*WB +: WB], WB'(k * 'h400 + i - 6));
                    end
                end
            end
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({vld_ob, d_ob, dly_ob} !== {1'b0, (LB*WB)'(0), DWB'(24)}) begin
            errors++;
            $display("FAIL midreset_b: got vld=%b d=%h dly=%0d", vld_ob, d_ob, dly_ob);
        end
        vectors++;
        if ({vld_oa, d_oa, dly_oa} !== {1'b0, (LA*WA)'(0), DWA'(32)}) begin
            errors++;
            $display("FAIL midreset_a: got vld=%b d=%h dly=%0d", vld_oa, d_oa, dly_oa);
        end
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step_b(1'b1, 1'b0, 1'b0, '0, 1'($urandom), (LB*WB)'({$urandom, $urandom}));
            vectors++;
            if ({vld_ob, d_ob} !== exp_b()) begin
                errors++;
                $display("FAIL postreset_b step %0d: got %h, want %h", i, {vld_ob, d_ob}, exp_b());
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en_a = 1'b0; flush_a = 1'b0; cfg_a = 1'b0; vld_a = 1'b0; dly_ia = '0; d_ia = '0;
        en_b = 1'b0; flush_b = 1'b0; cfg_b = 1'b0; vld_b = 1'b0; dly_ib = '0; d_ib = '0;
        model_reset();
        #2;
        test_reset();
        test_delay_load();
        test_stall();
        test_flush();
        test_random_mix();
        test_wrap();
        test_lanes();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
